// File: rtl/iter_alu.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops plus iterative MULTU/DIVU behind start/ready/done.
// Optional macro ITER_ALU_OVF_EN adds a registered signed-overflow flag (ovf) for ADD/SUB.
module iter_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             zero
`ifdef ITER_ALU_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1001;
   localparam logic [3:0] OP_MULT = 4'b1010;
   localparam logic [3:0] OP_DIVU = 4'b1011;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;

   logic [WIDTH-1:0] sc_lo;
   logic [WIDTH-1:0] sum_add, sum_sub;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;
   logic [WIDTH:0]   div_sh, div_diff;
   logic             div_ok;
   logic [WIDTH-1:0] div_hi, div_lo;

`ifdef ITER_ALU_OVF_EN
   logic ovf_q, ovf_d;
   logic sc_ovf;
`endif

   // Single-cycle result datapath
   always_comb begin
      sum_add = a + b;
      sum_sub = a - b;
      sc_lo   = '0;
      case (op)
         OP_ADD:  sc_lo = sum_add;
         OP_SUB:  sc_lo = sum_sub;
         OP_AND:  sc_lo = a & b;
         OP_OR:   sc_lo = a | b;
         OP_SLL:  sc_lo = b << a[SHW-1:0];
         OP_SRL:  sc_lo = b >> a[SHW-1:0];
         OP_SLT:  sc_lo = WIDTH'($signed(a) < $signed(b));
         OP_SLTU: sc_lo = WIDTH'(a < b);
         OP_XOR:  sc_lo = a ^ b;
         OP_NOR:  sc_lo = ~(a | b);
         default: sc_lo = '0;
      endcase
   end

`ifdef ITER_ALU_OVF_EN
   // Overflow: same-sign add or opposite-sign subtract whose result sign flips
   always_comb begin
      sc_ovf = 1'b0;
      if (op == OP_ADD)
         sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
      else if (op == OP_SUB)
         sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
   end
`endif

   // One shift-add multiply step and one restoring-divide step on the accumulator
   always_comb begin
      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_hi   = mul_sum[WIDTH:1];
      mul_lo   = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_ok   = (div_sh >= {1'b0, opnd_q});
      div_diff = div_sh - {1'b0, opnd_q};
      div_hi   = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      div_lo   = {acc_lo_q[WIDTH-2:0], div_ok};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      done_d   = 1'b0;
      ready_d  = ready_q;
`ifdef ITER_ALU_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MULT || op == OP_DIVU) begin
                  state_d  = (op == OP_MULT) ? S_MUL : S_DIV;
                  cnt_d    = CW'(WIDTH);
                  acc_hi_d = '0;
                  acc_lo_d = (op == OP_MULT) ? b : a;
                  opnd_d   = (op == OP_MULT) ? a : b;
                  ready_d  = 1'b0;
               end else begin
                  lo_d   = sc_lo;
                  hi_d   = '0;
                  done_d = 1'b1;
`ifdef ITER_ALU_OVF_EN
                  ovf_d  = sc_ovf;
`endif
               end
            end
         end
         S_MUL, S_DIV: begin
            cnt_d    = cnt_q - CW'(1);
            acc_hi_d = (state_q == S_MUL) ? mul_hi : div_hi;
            acc_lo_d = (state_q == S_MUL) ? mul_lo : div_lo;
            if (cnt_q == CW'(1)) begin
               lo_d    = acc_lo_d;
               hi_d    = acc_hi_d;
               done_d  = 1'b1;
               ready_d = 1'b1;
               state_d = S_IDLE;
`ifdef ITER_ALU_OVF_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
      endcase
      zero_d = (lo_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
`ifdef ITER_ALU_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
`ifdef ITER_ALU_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign ready = ready_q;
   assign done  = done_q;
   assign lo    = lo_q;
   assign hi    = hi_q;
   assign zero  = zero_q;
`ifdef ITER_ALU_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu (WIDTH=32): vector table plus reset-abort, busy-ignore and back-to-back sequences.
module tb_iter_alu;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] a, b, lo, hi;
   logic         ready, done, zero;
`ifdef ITER_ALU_OVF_EN
   logic         ovf;
`endif

   iter_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .ready (ready),
      .done  (done),
      .lo    (lo),
      .hi    (hi),
      .zero  (zero)
`ifdef ITER_ALU_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           lat;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         ovf;
      string        name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic add_vec(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int lat, input logic [W-1:0] el, input logic [W-1:0] eh,
                          input logic eo, input string nm);
      vec_t v;
      v.op = o; v.a = x; v.b = y; v.lat = lat; v.lo = el; v.hi = eh; v.ovf = eo; v.name = nm;
      vecs.push_back(v);
   endtask

   // Present a request for one rising edge; returns #1 after the accepting edge
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after the accepting edge until done is seen (bounded)
   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   int lat;
   int pulses;
   logic [W-1:0] prev_lo;

   initial begin
      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;

      add_vec(4'b0000, 32'd5,        32'd3,        0,  32'd8,        32'd0,        1'b0, "add_5_3");
      add_vec(4'b0001, 32'd7,        32'd7,        0,  32'd0,        32'd0,        1'b0, "sub_7_7");
      add_vec(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 0,  32'hF000F000, 32'd0,        1'b0, "and");
      add_vec(4'b0011, 32'h0F0F0000, 32'h000000F0, 0,  32'h0F0F00F0, 32'd0,        1'b0, "or");
      add_vec(4'b0110, 32'hFFFFFFFF, 32'd1,        0,  32'd1,        32'd0,        1'b0, "slt");
      add_vec(4'b0111, 32'hFFFFFFFF, 32'd1,        0,  32'd0,        32'd0,        1'b0, "sltu");
      add_vec(4'b0100, 32'h00000024, 32'd1,        0,  32'h00000010, 32'd0,        1'b0, "sll");
      add_vec(4'b0101, 32'd31,       32'h80000000, 0,  32'd1,        32'd0,        1'b0, "srl");
      add_vec(4'b1000, 32'hFFFF0000, 32'h0F0F0F0F, 0,  32'hF0F00F0F, 32'd0,        1'b0, "xor");
      add_vec(4'b1001, 32'hFFFF0000, 32'h0000FFF0, 0,  32'h0000000F, 32'd0,        1'b0, "nor");
      add_vec(4'b1100, 32'd5,        32'd3,        0,  32'd0,        32'd0,        1'b0, "op_1100");
      add_vec(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,  32'd0,        32'd0,        1'b0, "op_1111");
      add_vec(4'b1010, 32'd7,        32'd6,        32, 32'd42,       32'd0,        1'b0, "multu_7_6");
      add_vec(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h00000001, 32'hFFFFFFFE, 1'b0, "multu_max");
      add_vec(4'b1011, 32'd100,      32'd7,        32, 32'd14,       32'd2,        1'b0, "divu_100_7");
      add_vec(4'b1011, 32'd100,      32'd0,        32, 32'hFFFFFFFF, 32'd100,      1'b0, "divu_by_0");
      add_vec(4'b0000, 32'h7FFFFFFF, 32'd1,        0,  32'h80000000, 32'd0,        1'b1, "add_ovf");
      add_vec(4'b0001, 32'h80000000, 32'd1,        0,  32'h7FFFFFFF, 32'd0,        1'b1, "sub_ovf");
      add_vec(4'b0000, 32'd1,        32'd1,        0,  32'd2,        32'd0,        1'b0, "add_1_1");

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_done",  64'(done),  64'd0);
      chk("rst_lo",    64'(lo),    64'd0);
      chk("rst_hi",    64'(hi),    64'd0);
      chk("rst_zero",  64'(zero),  64'd1);

      // Reset in the middle of a divide aborts it with no done pulse
      issue(4'b0000, 32'd5, 32'd3);
      chk("pre_abort_lo", 64'(lo), 64'd8);
      issue(4'b1011, 32'd100, 32'd7);
      chk("abort_busy", 64'(ready), 64'd0);
      repeat (5) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("abort_ready", 64'(ready), 64'd1);
      chk("abort_done",  64'(done),  64'd0);
      chk("abort_lo",    64'(lo),    64'd0);
      chk("abort_zero",  64'(zero),  64'd1);
      @(negedge clk); rst_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk("abort_no_done", 64'(pulses), 64'd0);
      chk("abort_ready_after", 64'(ready), 64'd1);

      // Vector table
      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(0, lat);
         chk({vecs[i].name, "_lat"},  64'(lat),            64'(vecs[i].lat));
         chk({vecs[i].name, "_lo"},   64'(lo),             64'(vecs[i].lo));
         chk({vecs[i].name, "_hi"},   64'(hi),             64'(vecs[i].hi));
         chk({vecs[i].name, "_zero"}, 64'(zero),           64'(vecs[i].lo == '0));
`ifdef ITER_ALU_OVF_EN
         chk({vecs[i].name, "_ovf"},  64'(ovf),            64'(vecs[i].ovf));
`endif
         @(posedge clk); #1;
         chk({vecs[i].name, "_done_pulse"}, 64'(done), 64'd0);
      end

      // Start while busy is ignored and not queued
      issue(4'b0011, 32'h0000000F, 32'h000000F0);
      prev_lo = lo;
      issue(4'b1011, 32'd100, 32'd7);
      @(negedge clk);
      start = 1'b1; op = 4'b0000; a = 32'd5; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_done", 64'(done), 64'd0);
      chk("busy_lo",   64'(lo),   64'(prev_lo));
      chk("busy_hi",   64'(hi),   64'd0);
      wait_done(1, lat);
      chk("busy_div_lat", 64'(lat), 64'd32);
      chk("busy_div_lo",  64'(lo),  64'd14);
      chk("busy_div_hi",  64'(hi),  64'd2);
      @(posedge clk); #1;
      chk("busy_no_queue", 64'(done), 64'd0);
      chk("busy_lo_hold",  64'(lo),   64'd14);

      // Start in the done cycle is accepted back-to-back
      issue(4'b1010, 32'd7, 32'd6);
      wait_done(0, lat);
      chk("b2b_mul_lat", 64'(lat), 64'd32);
      chk("b2b_ready",   64'(ready), 64'd1);
      @(negedge clk);
      start = 1'b1; op = 4'b0011; a = 32'h0000000F; b = 32'h000000F0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_done", 64'(done), 64'd1);
      chk("b2b_lo",   64'(lo),   64'h000000FF);
      chk("b2b_hi",   64'(hi),   64'd0);
      @(posedge clk); #1;
      chk("b2b_done_drop", 64'(done), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
